// File: rtl/montgomery_ladder_exp.sv
`default_nettype none
// ============================================================================
// Module      : montgomery_ladder_exp
// Description : Constant-time modular exponentiation (Montgomery ladder) that
//               drives an external multiplier over a req/ack handshake.
// Revision    : 1.0 - initial release
// ============================================================================
module montgomery_ladder_exp #(
    parameter int WIDTH     = 512,
    parameter int LOG_WIDTH = 9
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     base_mont,
    input  logic [WIDTH-1:0]     exponent,
    input  logic [LOG_WIDTH:0]   exp_len,
    input  logic [WIDTH-1:0]     one_mont,
    output logic                 busy,
    output logic                 finish,
    output logic [WIDTH-1:0]     exp_result,
    output logic                 mult_req,
    output logic [WIDTH-1:0]     mult_a,
    output logic [WIDTH-1:0]     mult_b,
    input  logic                 mult_ack,
    input  logic [WIDTH-1:0]     mult_p
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_MUL_ISSUE = 3'd1,
        S_MUL_WAIT  = 3'd2,
        S_SQ_ISSUE  = 3'd3,
        S_SQ_WAIT   = 3'd4,
        S_FINISH    = 3'd5
    } state_t;

    localparam logic [LOG_WIDTH:0] c_MAX_LEN = (LOG_WIDTH+1)'(WIDTH);

    state_t                 r_state;
    logic [WIDTH-1:0]       r_r0;
    logic [WIDTH-1:0]       r_r1;
    logic [WIDTH-1:0]       r_exp;
    logic [LOG_WIDTH-1:0]   r_cnt;
    logic                   r_busy;
    logic                   r_finish;
    logic                   r_mult_req;
    logic [WIDTH-1:0]       r_mult_a;
    logic [WIDTH-1:0]       r_mult_b;

    logic [LOG_WIDTH:0]     w_len;
    logic [LOG_WIDTH-1:0]   w_cnt_init;
    logic                   w_bit;

    assign w_len      = (exp_len > c_MAX_LEN) ? c_MAX_LEN : exp_len;
    // len == WIDTH wraps the low bits to WIDTH-1, which is the intended top index
    assign w_cnt_init = w_len[LOG_WIDTH-1:0] - LOG_WIDTH'(1);
    assign w_bit      = r_exp[r_cnt];

    assign busy       = r_busy;
    assign finish     = r_finish;
    assign exp_result = r_r0;
    assign mult_req   = r_mult_req;
    assign mult_a     = r_mult_a;
    assign mult_b     = r_mult_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_r0       <= '0;
            r_r1       <= '0;
            r_exp      <= '0;
            r_cnt      <= '0;
            r_busy     <= 1'b0;
            r_finish   <= 1'b0;
            r_mult_req <= 1'b0;
            r_mult_a   <= '0;
            r_mult_b   <= '0;
        end else begin
            r_finish   <= 1'b0;
            r_mult_req <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_exp  <= exponent;
                        r_r0   <= one_mont;
                        r_r1   <= base_mont;
                        r_cnt  <= w_cnt_init;
                        r_busy <= 1'b1;
                        if (w_len == '0) begin
                            r_state  <= S_FINISH;
                            r_finish <= 1'b1;
                        end else begin
                            r_state    <= S_MUL_ISSUE;
                            r_mult_req <= 1'b1;
                            r_mult_a   <= one_mont;
                            r_mult_b   <= base_mont;
                        end
                    end
                end
                S_MUL_ISSUE: r_state <= S_MUL_WAIT;
                S_MUL_WAIT: begin
                    if (mult_ack) begin
                        if (w_bit) r_r0 <= mult_p;
                        else       r_r1 <= mult_p;
                        // The square operand is the register the multiply did not touch
                        r_mult_a   <= w_bit ? r_r1 : r_r0;
                        r_mult_b   <= w_bit ? r_r1 : r_r0;
                        r_mult_req <= 1'b1;
                        r_state    <= S_SQ_ISSUE;
                    end
                end
                S_SQ_ISSUE: r_state <= S_SQ_WAIT;
                S_SQ_WAIT: begin
                    if (mult_ack) begin
                        if (w_bit) r_r1 <= mult_p;
                        else       r_r0 <= mult_p;
                        if (r_cnt == '0) begin
                            r_state  <= S_FINISH;
                            r_finish <= 1'b1;
                        end else begin
                            // Next multiply operands are R0/R1 after this write-back
                            r_cnt      <= r_cnt - LOG_WIDTH'(1);
                            r_mult_a   <= w_bit ? r_r0 : mult_p;
                            r_mult_b   <= w_bit ? mult_p : r_r1;
                            r_mult_req <= 1'b1;
                            r_state    <= S_MUL_ISSUE;
                        end
                    end
                end
                S_FINISH: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_montgomery_ladder_exp.sv
`default_nettype none
// ============================================================================
// Module      : tb_montgomery_ladder_exp
// Description : Self-checking bench; modular multiplier mod 1009 with
//               configurable latency and an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_montgomery_ladder_exp;

    localparam int W    = 16;
    localparam int LW   = 4;
    localparam int MODP = 1009;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  base_mont;
    logic [W-1:0]  exponent;
    logic [LW:0]   exp_len;
    logic [W-1:0]  one_mont;
    logic          busy;
    logic          finish;
    logic [W-1:0]  exp_result;
    logic          mult_req;
    logic [W-1:0]  mult_a;
    logic [W-1:0]  mult_b;
    logic          mult_ack;
    logic [W-1:0]  mult_p;

    montgomery_ladder_exp #(.WIDTH(W), .LOG_WIDTH(LW)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .base_mont  (base_mont),
        .exponent   (exponent),
        .exp_len    (exp_len),
        .one_mont   (one_mont),
        .busy       (busy),
        .finish     (finish),
        .exp_result (exp_result),
        .mult_req   (mult_req),
        .mult_a     (mult_a),
        .mult_b     (mult_b),
        .mult_ack   (mult_ack),
        .mult_p     (mult_p)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_chk  = 0;
    int n_pass = 0;

    function automatic void check(input string name, input longint act, input longint req);
        n_chk++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, req, cyc);
    endfunction

    // Right-to-left binary exponentiation, independent of the ladder order
    function automatic int model_exp(input int base, input int e, input int len);
        int l;
        int res;
        int pw;
        l   = (len > W) ? W : len;
        res = 1;
        pw  = base % MODP;
        for (int i = 0; i < l; i++) begin
            if (((e >> i) & 1) == 1) res = (res * pw) % MODP;
            pw = (pw * pw) % MODP;
        end
        return res;
    endfunction

    int     lat_fixed = 1;
    bit     spur_en   = 1'b0;
    int     req_cnt   = 0;
    int     req_off[$];
    int     m_start   = 0;
    int     m_active  = 0;
    int     m_res     = 0;
    int     m_hold    = 0;
    int     m_fin_exp = -1;
    bit     chk_en    = 1'b0;
    int     lat;
    logic [W-1:0] a_l;
    logic [W-1:0] b_l;

    // Behavioural multiplier: ack L cycles after the request cycle
    initial begin
        mult_ack = 1'b0;
        mult_p   = '0;
        forever begin
            @(negedge clk);
            if (mult_req && !rst) begin
                a_l = mult_a;
                b_l = mult_b;
                lat = (lat_fixed > 0) ? lat_fixed : int'($urandom_range(1, 6));
                req_cnt++;
                req_off.push_back(cyc - m_start);
                if (spur_en) begin
                    mult_ack = 1'b1;
                    mult_p   = 16'h0123;
                end
                for (int k = 0; k < lat; k++) begin
                    @(posedge clk);
                    #1;
                    mult_ack = 1'b0;
                end
                if (busy) begin
                    check("operand_a_stable", mult_a, a_l);
                    check("operand_b_stable", mult_b, b_l);
                end
                mult_ack = 1'b1;
                mult_p   = W'((int'(a_l) * int'(b_l)) % MODP);
                @(posedge clk);
                #1;
                mult_ack = 1'b0;
                mult_p   = '0;
            end
        end
    end

    // Per-cycle compare against the model
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && chk_en) begin
                if (m_active != 0 && cyc > m_start) begin
                    if (finish) begin
                        check("result", exp_result, m_res);
                        if (m_fin_exp >= 0) check("finish_cycle", cyc - m_start, m_fin_exp);
                        check("busy_at_finish", busy, 1);
                        m_hold   = m_res;
                        m_active = 0;
                    end else begin
                        check("busy_during_op", busy, 1);
                    end
                end else begin
                    check("idle_busy", busy, 0);
                    check("idle_finish", finish, 0);
                    check("idle_mult_req", mult_req, 0);
                    check("idle_result_held", exp_result, m_hold);
                end
            end
        end
    end

    task automatic run_op(input int base, input int e, input int len, input int l_cfg,
                          input bit spur, input bit poke);
        int eff;
        int budget;
        eff       = (len > W) ? W : len;
        lat_fixed = l_cfg;
        spur_en   = spur;
        @(posedge clk);
        #1;
        base_mont = W'(base);
        exponent  = W'(e);
        exp_len   = (LW+1)'(len);
        start     = 1'b1;
        m_start   = cyc;
        m_res     = model_exp(base, e, len);
        m_fin_exp = (l_cfg > 0) ? 1 + 2 * eff * (l_cfg + 1) : -1;
        req_cnt   = 0;
        req_off.delete();
        m_active  = 1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (poke) begin
            base_mont = 16'd999;
            exponent  = 16'hFFFF;
            exp_len   = 5'd5;
            repeat (3) begin
                @(posedge clk);
                #1 start = 1'b1;
                @(posedge clk);
                #1 start = 1'b0;
            end
        end
        budget = 0;
        while (m_active != 0 && budget < 3000) begin
            @(posedge clk);
            budget++;
        end
        if (m_active != 0) begin
            check("finish_timeout", 0, 1);
            m_active = 0;
        end
        check("req_count", req_cnt, 2 * eff);
        if (l_cfg > 0)
            for (int k = 0; k < req_off.size(); k++)
                check("req_offset", req_off[k], 1 + k * (l_cfg + 1));
    endtask

    initial begin
        int budget;
        #500000;
        $display("FAIL global_timeout: got running, expected finished");
        $fatal(1);
    end

    initial begin
        int budget;
        rst       = 1'b1;
        start     = 1'b0;
        base_mont = '0;
        exponent  = '0;
        exp_len   = '0;
        one_mont  = 16'd1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_finish", finish, 0);
        check("rst_mult_req", mult_req, 0);
        check("rst_result", exp_result, 0);
        check("rst_mult_a", mult_a, 0);
        check("rst_mult_b", mult_b, 0);
        chk_en = 1'b1;

        check("model_pin_3_13", model_exp(3, 13, 4), 103);
        check("model_pin_2_10", model_exp(2, 10, 4), 15);
        check("model_pin_len0", model_exp(7, 5, 0), 1);
        check("model_pin_clamp", model_exp(3, 13, 31), 103);

        run_op(3, 13, 4, 1, 1'b0, 1'b0);
        run_op(3, 13, 8, 3, 1'b0, 1'b0);
        run_op(5, 8'h00, 8, 2, 1'b0, 1'b0);
        run_op(5, 8'hFF, 8, 2, 1'b0, 1'b0);
        run_op(4, 16'hBEEF, 0, 1, 1'b0, 1'b0);
        run_op(7, 16'hA5C3, 31, 1, 1'b0, 1'b0);
        run_op(7, 16'hA5C3, 16, 1, 1'b0, 1'b0);
        run_op(11, 16'h1234, 12, 2, 1'b0, 1'b1);
        run_op(6, 16'h0F0F, 16, 1, 1'b1, 1'b0);
        run_op(13, 16'hC35A, 16, 0, 1'b0, 1'b0);
        run_op(17, 16'h8001, 16, 0, 1'b1, 1'b0);

        // Abort during SQ_WAIT of bit 5 (sixth request of an 8-bit run)
        lat_fixed = 2;
        spur_en   = 1'b0;
        @(posedge clk);
        #1;
        base_mont = 16'd3;
        exponent  = 16'h00B7;
        exp_len   = 5'd8;
        start     = 1'b1;
        m_start   = cyc;
        m_res     = model_exp(3, 16'h00B7, 8);
        m_fin_exp = -1;
        req_cnt   = 0;
        req_off.delete();
        m_active  = 1;
        @(posedge clk);
        #1 start = 1'b0;
        budget = 0;
        do begin
            @(posedge clk);
            budget++;
        end while (req_cnt < 6 && budget < 500);
        if (req_cnt < 6) check("abort_wait_timeout", req_cnt, 6);
        #1;
        m_active = 0;
        m_hold   = 0;
        rst      = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("abort_busy", busy, 0);
        check("abort_result", exp_result, 0);
        check("abort_mult_req", mult_req, 0);
        check("abort_finish", finish, 0);
        check("abort_mult_a", mult_a, 0);
        repeat (4) @(posedge clk);
        run_op(3, 13, 4, 1, 1'b0, 1'b0);

        repeat (3) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
